// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types and helpers for the sign-magnitude frame accumulator
package sm_pkg;

  localparam int SM_N_DEF     = 8;
  localparam int SM_ACC_W_DEF = 9;
  localparam int MAG_MAX      = 2**(SM_ACC_W_DEF-1) - 1;

  typedef enum logic {ST_ACC, ST_HOLD} sm_state_e;

  // A zero magnitude always carries a positive sign, so -0 never escapes.
  function automatic logic sm_norm(input logic sign, input logic mag_zero);
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/sm_ovf_add.sv
// rtl/sm_ovf_add.sv - combinational sign-magnitude adder with overflow flag
// SM_ACC_SAT_EN: saturate the magnitude on overflow instead of wrapping.
module sm_ovf_add
  import sm_pkg::*;
#(
  parameter int ACC_W = SM_ACC_W_DEF
) (
  input  logic             a_sign,
  input  logic [ACC_W-2:0] a_mag,
  input  logic             b_sign,
  input  logic [ACC_W-2:0] b_mag,
  output logic             sum_sign,
  output logic [ACC_W-2:0] sum_mag,
  output logic             ovf
);

  logic [ACC_W-1:0] mag_sum;
  logic             raw_sign;
  logic [ACC_W-2:0] raw_mag;

  always_comb begin
    mag_sum  = {1'b0, a_mag} + {1'b0, b_mag};
    ovf      = 1'b0;
    raw_sign = a_sign;
    raw_mag  = mag_sum[ACC_W-2:0];
    if (a_sign == b_sign) begin
      ovf = mag_sum[ACC_W-1];
`ifdef SM_ACC_SAT_EN
      if (mag_sum[ACC_W-1]) raw_mag = '1;
`else
      raw_mag = mag_sum[ACC_W-2:0];
`endif
    end else if (a_mag >= b_mag) begin
      raw_mag = a_mag - b_mag;
    end else begin
      raw_sign = b_sign;
      raw_mag  = b_mag - a_mag;
    end
    sum_mag  = raw_mag;
    sum_sign = sm_norm(raw_sign, raw_mag == '0);
  end

endmodule

// File: rtl/sign_mag_acc.sv
// rtl/sign_mag_acc.sv - frame accumulator of sign-magnitude samples with handshake
// Overflow handling selected by SM_ACC_SAT_EN (saturate) or wrap when undefined.
module sign_mag_acc
  import sm_pkg::*;
#(
  parameter int N     = SM_N_DEF,
  parameter int ACC_W = SM_ACC_W_DEF,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(LEN);

  sm_state_e        state, state_nxt;
  logic             acc_sign, acc_sign_nxt;
  logic [ACC_W-2:0] acc_mag, acc_mag_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt;

  logic             add_sign;
  logic [ACC_W-2:0] add_mag;
  logic             add_ovf;
  logic [ACC_W-2:0] smp_mag;

  assign smp_mag = {{(ACC_W-N){1'b0}}, in_data[N-2:0]};

  sm_ovf_add #(.ACC_W(ACC_W)) u_add (
    .a_sign   (acc_sign),
    .a_mag    (acc_mag),
    .b_sign   (in_data[N-1]),
    .b_mag    (smp_mag),
    .sum_sign (add_sign),
    .sum_mag  (add_mag),
    .ovf      (add_ovf)
  );

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign out_data  = {acc_sign, acc_mag};
  assign out_ovf   = ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_ACC;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc_sign <= acc_sign_nxt;
      acc_mag  <= acc_mag_nxt;
      count    <= count_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // clear outranks both sample acceptance and the output handshake.
  always_comb begin
    state_nxt    = state;
    acc_sign_nxt = acc_sign;
    acc_mag_nxt  = acc_mag;
    count_nxt    = count;
    ovf_nxt      = ovf;
    if (clear) begin
      state_nxt    = ST_ACC;
      acc_sign_nxt = 1'b0;
      acc_mag_nxt  = '0;
      count_nxt    = '0;
      ovf_nxt      = 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc_sign_nxt = add_sign;
            acc_mag_nxt  = add_mag;
            ovf_nxt      = ovf | add_ovf;
            if (count == CNT_W'(LEN-1)) begin
              count_nxt = '0;
              state_nxt = ST_HOLD;
            end else begin
              count_nxt = count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_nxt    = ST_ACC;
            acc_sign_nxt = 1'b0;
            acc_mag_nxt  = '0;
            ovf_nxt      = 1'b0;
          end
        end
        default: state_nxt = ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_mag_acc.sv
// tb/tb_sign_mag_acc.sv - self-checking bench for sign_mag_acc with a signed-integer reference model
module tb_sign_mag_acc;

  typedef logic [7:0] frame_t [4];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_ovf;

  int n_checks = 0;
  int n_fail = 0;

  sign_mag_acc #(.N(8), .ACC_W(9), .LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: running total as a signed integer, limited to +/-255 per step.
  function automatic void model_step(inout int v, inout bit o, input logic [7:0] s);
    int sv;
    int m;
    sv = s[7] ? -int'(s[6:0]) : int'(s[6:0]);
    v = v + sv;
    m = (v < 0) ? -v : v;
    if (m > 255) begin
      o = 1'b1;
`ifdef SM_ACC_SAT_EN
      m = 255;
`else
      m = m % 256;
`endif
      v = (v < 0) ? -m : m;
    end
  endfunction

  function automatic logic [8:0] enc(input int v);
    logic [8:0] r;
    r = (v < 0) ? {1'b1, 8'(-v)} : {1'b0, 8'(v)};
    return r;
  endfunction

  task automatic push(input logic [7:0] s);
    int t;
    t = 0;
    @(negedge clk);
    in_data = s;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed(input frame_t f, output logic [8:0] exp_d, output bit exp_o);
    int v;
    bit o;
    v = 0;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(f[i]);
      model_step(v, o, f[i]);
    end
    exp_d = enc(v);
    exp_o = o;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_data, out_valid, out_ovf, in_ready} !== {9'h000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state data=%h valid=%b ovf=%b ready=%b required 000/0/0/1", out_data, out_valid, out_ovf, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release ready=%b valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_mixed();
    push(8'h05); push(8'h83); push(8'h0A);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_early_valid out_valid=%b required 0", out_valid);
    end
    push(8'h82);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h00A || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_total valid=%b data=%h ovf=%b required 1/00a/0", out_valid, out_data, out_ovf);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 9'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_release valid=%b data=%h ready=%b required 0/000/1", out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_cancel();
    logic [8:0] d;
    bit o;
    feed('{8'h03, 8'h83, 8'h07, 8'h87}, d, o);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h000 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_total valid=%b data=%h ovf=%b required 1/000/0", out_valid, out_data, out_ovf);
    end
    release_out();
  endtask

  task automatic test_overflow();
    int v;
    bit o;
    v = 0;
    o = 1'b0;
    push(8'h7F); model_step(v, o, 8'h7F);
    push(8'h7F); model_step(v, o, 8'h7F);
    push(8'h7F); model_step(v, o, 8'h7F);
    n_checks++;
    if (out_data !== enc(v) || out_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_step3 data=%h ovf=%b required %h/1", out_data, out_ovf, enc(v));
    end
    push(8'hE4); model_step(v, o, 8'hE4);
    n_checks++;
`ifdef SM_ACC_SAT_EN
    if (out_data !== 9'h09B || out_ovf !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_total data=%h ovf=%b valid=%b required 09b/1/1", out_data, out_ovf, out_valid);
    end
`else
    if (out_data !== 9'h019 || out_ovf !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_total data=%h ovf=%b valid=%b required 019/1/1", out_data, out_ovf, out_valid);
    end
`endif
    release_out();
    n_checks++;
    if (out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared out_ovf=%b required 0", out_ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] d;
    bit o;
    feed('{8'h05, 8'h06, 8'h07, 8'h08}, d, o);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'h09;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d valid=%b data=%h ovf=%b ready=%b required 1/%h/0/0", i, out_valid, out_data, out_ovf, in_ready, d);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 9'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release valid=%b data=%h ready=%b required 0/000/1", out_valid, out_data, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_data !== 9'h009) begin
      n_fail++;
      $display("FAIL bp_first_sample data=%h required 009", out_data);
    end
    push(8'h01); push(8'h01); push(8'h01);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h00C) begin
      n_fail++;
      $display("FAIL bp_next_frame valid=%b data=%h required 1/00c", out_valid, out_data);
    end
    release_out();
  endtask

  task automatic test_abort();
    logic [8:0] d;
    bit o;
    push(8'h14); push(8'h14);
    n_checks++;
    if (out_data !== 9'h028) begin
      n_fail++;
      $display("FAIL abort_partial data=%h required 028", out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_data, out_valid, out_ovf, in_ready} !== {9'h000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_reset data=%h valid=%b ovf=%b ready=%b required 000/0/0/1", out_data, out_valid, out_ovf, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    push(8'h14); push(8'h14);
    @(negedge clk);
    clear = 1'b1;
    n_checks++;
    if (out_data !== 9'h028) begin
      n_fail++;
      $display("FAIL abort_clear_sync data=%h required 028 before edge", out_data);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_checks++;
    if ({out_data, out_valid, out_ovf, in_ready} !== {9'h000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_clear data=%h valid=%b ovf=%b ready=%b required 000/0/0/1", out_data, out_valid, out_ovf, in_ready);
    end
    feed('{8'h01, 8'h01, 8'h01, 8'h01}, d, o);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h004 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_frame valid=%b data=%h ovf=%b required 1/004/0", out_valid, out_data, out_ovf);
    end
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 9'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_clear_hold valid=%b data=%h ready=%b required 0/000/1", out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_negative();
    logic [8:0] d;
    bit o;
    feed('{8'hB2, 8'hBC, 8'h05, 8'h81}, d, o);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h16A || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL negative_total valid=%b data=%h ovf=%b required 1/16a/0", out_valid, out_data, out_ovf);
    end
    release_out();
  endtask

  task automatic test_random();
    frame_t f;
    int v;
    bit o;
    for (int fr = 0; fr < 30; fr++) begin
      v = 0;
      o = 1'b0;
      for (int i = 0; i < 4; i++) f[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push(f[i]);
        model_step(v, o, f[i]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== enc(v) || out_ovf !== o) begin
        n_fail++;
        $display("FAIL random_frame%0d valid=%b data=%h ovf=%b required 1/%h/%b", fr, out_valid, out_data, out_ovf, enc(v), o);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_cancel();
    test_overflow();
    test_backpressure();
    test_abort();
    test_negative();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sign_mag_acc.md
Name: sign_mag_acc

Overview:
- Downstream consumer of the combinational sign-magnitude adder stage.
- Accumulates a frame of LEN sign-magnitude samples into a wider sign-magnitude register, using a valid/ready handshake on input and output.
- Presents the frame total with an overflow flag, then clears and starts the next frame.
- Sits between sample producers and the frame-level post-processing logic.

Parameters:
- N, 8: input sample width including sign bit (bit N-1 = sign, N-2:0 = magnitude).
- ACC_W, 9: accumulator/result width including sign bit; ACC_W > N.
- LEN, 4: samples per frame, >= 2. Counter width is $clog2(LEN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort; zeroes accumulator, counter and flag, returns to ACC state.
- in_data  in  N  sign-magnitude sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  high in ACC state only.
- out_data  out  ACC_W  sign-magnitude frame total.
- out_valid  out  1  high in HOLD state.
- out_ready  in  1  consumer accepts the total.
- out_ovf  out  1  sticky; set if any step of the frame overflowed the magnitude range.

Behaviour:
- Reset (asynchronous, active-high, one clock, clk): state=ACC, acc=+0, count=0, ovf=0. Resulting outputs: out_data=0, out_valid=0, out_ovf=0, in_ready=1. Reset mid-frame discards the partial sum.
- States:
  - ACC: in_ready=1. A sample is accepted on in_valid&&in_ready: acc <= acc (+) sample, count <= count+1.
  - ACC to HOLD: occurs when the LEN-th sample is accepted (count==LEN-1). count <= 0.
  - HOLD: out_valid=1, in_ready=0. out_data and out_ovf stay stable until out_ready.
  - HOLD to ACC: on out_ready, acc <= +0, ovf <= 0. The next sample is accepted one cycle later, so there is no same-cycle bypass.
- Sign-magnitude addition (+): the sample magnitude is zero-extended to ACC_W-1 bits.
  - Equal signs: magnitude = sum of magnitudes, sign kept.
  - Different signs: magnitude = larger minus smaller, sign of the larger.
  - Equal magnitudes with opposite signs: result is +0.
  - Any -0 result or input is normalised to +0; -0 is never stored or output.
- Overflow: occurs when the same-sign magnitude sum exceeds 2^(ACC_W-1)-1. It sets ovf. The clamping behaviour depends on the macro (see Optional Feature).
- Overflow is evaluated per accepted sample; the result is order-dependent, by design.
- Latency: the total is visible in the cycle after the last sample is accepted.
- Throughput: LEN+1 cycles per frame minimum.
- clear has priority over sample acceptance and out_ready. It is valid in either state; in HOLD it drops out_valid without a handshake.
- in_valid while in HOLD is ignored; the producer holds the sample.

Optional Feature:
- Macro: SM_ACC_SAT_EN.
- Defined: on overflow, the magnitude saturates to 2^(ACC_W-1)-1 with the operand sign, and ovf is set.
- Undefined: the magnitude wraps modulo 2^(ACC_W-1), keeping the sign, and ovf is still set. If the wrapped magnitude is 0, the result is +0.

Decomposition:
- Shared package sm_pkg:
  - state enum {ST_ACC, ST_HOLD};
  - function sm_norm (negative-zero fix);
  - localparam MAG_MAX.
- Sub-module sm_ovf_add: a combinational sign-magnitude adder with widths parameterised by ACC_W, an ovf output, and saturate/wrap selected by the macro.
- The accumulator FSM, counter and handshake live in sign_mag_acc.

Test Plan:
1. Mixed-sign frame, defaults: +5, -3, +10, -2 -> out_data=+10 (0x00A), out_ovf=0, out_valid the cycle after the 4th accept.
2. Cancellation: +3, -3, +7, -7 -> out_data=0x000 (never 0x100), out_ovf=0.
3. Saturation with SM_ACC_SAT_EN defined: +127 x2, then +127, then -100:
   - after the 3rd sample: 381 clamps to 255, ovf=1;
   - after the 4th: 155 -> out_data=+155 (0x09B), out_ovf=1.
   - Same frame with the macro undefined -> wrap to 381-256=125, final +25, out_ovf=1.
4. Backpressure: complete a frame, hold out_ready=0 for 3 cycles while in_valid=1 with +9 -> out_valid, out_data and out_ovf are stable, in_ready=0, +9 is not consumed. After out_ready, +9 is accepted as the first sample of the next frame and the next frame's acc starts from +0.
5. Reset/clear mid-frame: accept +20, +20, assert reset for 1 cycle -> all outputs 0. Repeat with clear instead -> same result synchronously. The next 4 samples (+1 each) give +4.
6. Negative totals: -50, -60, +5, -1 -> out_data = sign 1, magnitude 106 (0x16A), out_ovf=0.
